// File: rtl/delay_timer_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | delay_timer_bank_if : control/status bundle for delay_timer_bank   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface delay_timer_bank_if #(
   parameter int N_CH  = 2,
   parameter int SEC_W = 4
) ();
   logic [N_CH-1:0]       enable;
   logic [N_CH-1:0]       restart;
   logic [N_CH-1:0]       hold;
   logic [N_CH*SEC_W-1:0] dur_sec;
   logic [N_CH-1:0]       done;
   logic [N_CH-1:0]       done_pulse;
   logic [N_CH-1:0]       busy;
   logic [N_CH*SEC_W-1:0] rem_sec;

   modport master (
      output enable, restart, hold, dur_sec,
      input  done, done_pulse, busy, rem_sec
   );

   modport slave (
      input  enable, restart, hold, dur_sec,
      output done, done_pulse, busy, rem_sec
   );
endinterface
`default_nettype wire

// File: rtl/delay_timer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | delay_timer_bank : N_CH independent seconds timers with hold/restart|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module delay_timer_bank #(
   parameter int CLK_HZ = 50_000_000,
   parameter int N_CH   = 2,
   parameter int SEC_W  = 4
) (
   input logic               clk_50M,
   input logic               rst_n,
   delay_timer_bank_if.slave bus
);
   localparam int              CYC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(CLK_HZ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         state_t           r_state, w_state_nxt;
         logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
         logic [SEC_W-1:0] r_rem, w_rem_nxt, w_dur;
         logic             r_done, r_busy, r_pulse;

         assign w_dur = bus.dur_sec[i*SEC_W +: SEC_W];

         // A zero load spends one cycle in RUN, so done rises one edge after the load.
         always_comb begin
            w_state_nxt = r_state;
            w_cyc_nxt   = r_cyc;
            w_rem_nxt   = r_rem;
            if (!bus.enable[i]) begin
               w_state_nxt = ST_IDLE;
               w_cyc_nxt   = '0;
               w_rem_nxt   = '0;
            end else if (r_state == ST_IDLE || bus.restart[i]) begin
               w_state_nxt = ST_RUN;
               w_cyc_nxt   = '0;
               w_rem_nxt   = w_dur;
            end else if (r_state != ST_DONE) begin
               if (r_rem == '0) begin
                  w_state_nxt = ST_DONE;
               end else if (bus.hold[i]) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_RUN;
                  if (r_cyc == CYC_MAX) begin
                     w_cyc_nxt = '0;
                     w_rem_nxt = r_rem - SEC_W'(1);
                     if (r_rem == SEC_W'(1)) begin
                        w_state_nxt = ST_DONE;
                     end
                  end else begin
                     w_cyc_nxt = r_cyc + CYC_W'(1);
                  end
               end
            end
         end

         always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
               r_state <= ST_IDLE;
               r_cyc   <= '0;
               r_rem   <= '0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_pulse <= 1'b0;
            end else begin
               r_state <= w_state_nxt;
               r_cyc   <= w_cyc_nxt;
               r_rem   <= w_rem_nxt;
               r_done  <= (w_state_nxt == ST_DONE);
               r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
               r_pulse <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
            end
         end

         assign bus.done[i]                  = r_done;
         assign bus.busy[i]                  = r_busy;
         assign bus.done_pulse[i]            = r_pulse;
         assign bus.rem_sec[i*SEC_W +: SEC_W] = r_rem;
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_delay_timer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_delay_timer_bank : vector, sequence and random checks vs model  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_delay_timer_bank;
   localparam int C_HZ = 10;

   logic clk_50M = 1'b0;
   logic rst_n   = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   always #5 clk_50M = ~clk_50M;

   delay_timer_bank_if #(.N_CH(2), .SEC_W(4)) bus ();

   delay_timer_bank #(.CLK_HZ(C_HZ), .N_CH(2), .SEC_W(4)) dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .bus     (bus.slave)
   );

   // Reference: a channel is idle, counting (ticks of clock since load) or done.
   int m_mode [2];
   int m_ticks[2];
   int m_dur  [2];
   bit m_pulse[2];

   typedef struct {
      logic [3:0] d0, d1;
      int         n;
      logic [1:0] done, pulse, busy;
      logic [3:0] r0, r1;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_mode[c] = 0; m_ticks[c] = 0; m_dur[c] = 0; m_pulse[c] = 0;
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < 2; c++) begin
         m_pulse[c] = 0;
         if (!bus.enable[c]) begin
            m_mode[c] = 0; m_ticks[c] = 0; m_dur[c] = 0;
         end else if (m_mode[c] == 0 || bus.restart[c]) begin
            m_mode[c] = 1; m_ticks[c] = 0; m_dur[c] = int'(bus.dur_sec[c*4 +: 4]);
         end else if (m_mode[c] == 1) begin
            if (m_dur[c] == 0) begin
               m_mode[c] = 2; m_pulse[c] = 1;
            end else if (!bus.hold[c]) begin
               m_ticks[c]++;
               if (m_ticks[c] == m_dur[c] * C_HZ) begin
                  m_mode[c] = 2; m_pulse[c] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_model();
      logic [1:0] e_done, e_busy, e_pulse;
      logic [7:0] e_rem;
      for (int c = 0; c < 2; c++) begin
         e_done[c]  = (m_mode[c] == 2);
         e_busy[c]  = (m_mode[c] == 1);
         e_pulse[c] = m_pulse[c];
         e_rem[c*4 +: 4] = (m_mode[c] == 1) ? 4'(m_dur[c] - m_ticks[c] / C_HZ) : 4'd0;
      end
      check("model_done",  32'(bus.done),       32'(e_done));
      check("model_busy",  32'(bus.busy),       32'(e_busy));
      check("model_pulse", 32'(bus.done_pulse), 32'(e_pulse));
      check("model_rem",   32'(bus.rem_sec),    32'(e_rem));
   endtask

   // One rising edge: advance the model, then sample outputs 1 time unit later.
   task automatic tick();
      @(posedge clk_50M);
      model_step();
      #1;
      check_model();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_done"},  32'(bus.done),       32'd0);
      check({tag, "_busy"},  32'(bus.busy),       32'd0);
      check({tag, "_pulse"}, 32'(bus.done_pulse), 32'd0);
      check({tag, "_rem"},   32'(bus.rem_sec),    32'd0);
   endtask

   // Called between edges; reset is applied and checked asynchronously.
   task automatic start_run(input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] en);
      bus.restart = 2'b00;
      bus.hold    = 2'b00;
      rst_n       = 1'b0;
      #2;
      check_zero("reset");
      model_reset();
      bus.dur_sec = {d1, d0};
      bus.enable  = en;
      rst_n       = 1'b1;
   endtask

   initial begin
      vecs[0] = '{4'd5, 4'd3,  1, 2'b00, 2'b00, 2'b11, 4'd5, 4'd3};
      vecs[1] = '{4'd5, 4'd3, 11, 2'b00, 2'b00, 2'b11, 4'd4, 4'd2};
      vecs[2] = '{4'd3, 4'd5, 31, 2'b01, 2'b01, 2'b10, 4'd0, 4'd2};
      vecs[3] = '{4'd3, 4'd5, 51, 2'b11, 2'b10, 2'b00, 4'd0, 4'd0};
      vecs[4] = '{4'd0, 4'd1,  1, 2'b00, 2'b00, 2'b11, 4'd0, 4'd1};
      vecs[5] = '{4'd0, 4'd1,  2, 2'b01, 2'b01, 2'b10, 4'd0, 4'd1};
      vecs[6] = '{4'd5, 4'd15, 50, 2'b00, 2'b00, 2'b11, 4'd1, 4'd11};
      vecs[7] = '{4'd5, 4'd15, 51, 2'b01, 2'b01, 2'b10, 4'd0, 4'd10};

      bus.enable  = 2'b00;
      bus.restart = 2'b00;
      bus.hold    = 2'b00;
      bus.dur_sec = 8'h00;
      model_reset();
      repeat (2) @(posedge clk_50M);
      #1;
      check_zero("por");

      // Table: fresh start, n edges (edge 0 is the first), then fixed expectations.
      foreach (vecs[k]) begin
         start_run(vecs[k].d0, vecs[k].d1, 2'b11);
         for (int e = 0; e < vecs[k].n; e++) tick();
         check($sformatf("vec%0d_done", k),  32'(bus.done),          32'(vecs[k].done));
         check($sformatf("vec%0d_pulse", k), 32'(bus.done_pulse),    32'(vecs[k].pulse));
         check($sformatf("vec%0d_busy", k),  32'(bus.busy),          32'(vecs[k].busy));
         check($sformatf("vec%0d_rem0", k),  32'(bus.rem_sec[3:0]),  32'(vecs[k].r0));
         check($sformatf("vec%0d_rem1", k),  32'(bus.rem_sec[7:4]),  32'(vecs[k].r1));
      end

      // Hold for edges 12..19 delays done by 8 cycles.
      start_run(4'd3, 4'd0, 2'b01);
      for (int e = 0; e <= 40; e++) begin
         bus.hold[0] = (e >= 12 && e <= 19);
         tick();
         if (e >= 12 && e <= 19) check("hold_rem_frozen", 32'(bus.rem_sec[3:0]), 32'd2);
         if (e == 37) check("hold_done_early", 32'(bus.done[0]), 32'd0);
         if (e == 38) check("hold_done_at_38", 32'(bus.done[0]), 32'd1);
         if (e == 38) check("hold_pulse_at_38", 32'(bus.done_pulse[0]), 32'd1);
      end
      bus.hold = 2'b00;

      // Restart mid-run and again in DONE; a mid-run dur change must be ignored.
      start_run(4'd5, 4'd0, 2'b01);
      for (int e = 0; e <= 131; e++) begin
         bus.restart[0]      = (e == 25 || e == 80);
         bus.dur_sec[3:0]    = (e >= 40 && e < 60) ? 4'd9 : 4'd5;
         tick();
         if (e == 74)  check("rst_done_early",  32'(bus.done[0]), 32'd0);
         if (e == 75)  check("rst_done_at_75",  32'(bus.done[0]), 32'd1);
         if (e == 81)  check("rst_done_cleared", 32'(bus.done[0]), 32'd0);
         if (e == 129) check("rst_pulse2_early", 32'(bus.done_pulse[0]), 32'd0);
         if (e == 130) check("rst_pulse2_at_130", 32'(bus.done_pulse[0]), 32'd1);
         if (e == 131) check("rst_pulse2_width", 32'(bus.done_pulse[0]), 32'd0);
      end
      bus.restart = 2'b00;

      // Enable sampled low at edge 20 clears the channel on that edge.
      start_run(4'd5, 4'd0, 2'b01);
      for (int e = 0; e <= 20; e++) begin
         bus.enable[0] = (e < 20);
         tick();
      end
      check("endrop_busy", 32'(bus.busy[0]), 32'd0);
      check("endrop_rem",  32'(bus.rem_sec[3:0]), 32'd0);

      // Async reset mid-count, then rerun with enable already high.
      start_run(4'd3, 4'd0, 2'b01);
      for (int e = 0; e <= 15; e++) tick();
      rst_n = 1'b0;
      #2;
      check_zero("midreset");
      model_reset();
      rst_n = 1'b1;
      for (int e = 0; e <= 30; e++) begin
         tick();
         if (e == 29) check("rerun_done_early", 32'(bus.done[0]), 32'd0);
         if (e == 30) check("rerun_done_at_30", 32'(bus.done[0]), 32'd1);
      end

      // Random traffic against the model.
      start_run(4'd2, 4'd1, 2'b11);
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 49) == 0) bus.enable[c] = ~bus.enable[c];
            bus.restart[c] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) bus.hold[c] = ~bus.hold[c];
            if ($urandom_range(0, 29) == 0) bus.dur_sec[c*4 +: 4] = 4'($urandom_range(0, 3));
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
